uart_tx: RTL and testbench

- Serial transmitter that consumes the UART byte register exported by the MMIO block.
- Detects a new write by the toggle in bit 8 of `uart_tx_data` and buffers bytes in a small FIFO.
- Shifts bytes out as 8N1 frames on the `tx` pin.
- Returns busy status (`uart_tx_sending`) to the MMIO block so software can poll it.

---
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 serial transmitter fed by the MMIO byte register; a toggle on bit 8 marks each write.
// Bytes are buffered in a small circular FIFO and shifted out LSB first on tx.
`timescale 1ns/1ps
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] uart_tx_data,
    output logic       uart_tx_sending,
    output logic       uart_tx_full,
    output logic       uart_tx_overflow,
    output logic       tx
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              prev_toggle;
    logic              overflow;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    logic              baud_done;
    logic              new_byte;
    logic              pop;
    logic              push;
    logic              drop;

    // A pop frees a slot in the same cycle, so a write arriving at full is still taken then.
    always_comb begin
        baud_done = (baud_cnt == BAUD_LAST);
        new_byte  = (uart_tx_data[8] != prev_toggle);
        pop       = (count != '0) && ((state == IDLE) || ((state == STOP) && baud_done));
        push      = new_byte && ((count != DEPTH) || pop);
        drop      = new_byte && !push;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= uart_tx_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_toggle <= uart_tx_data[8];
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            prev_toggle <= uart_tx_data[8];
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // tx is registered from the current state, so the line follows the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[0];
                default: tx <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uart_tx_full     = (count == DEPTH);
    assign uart_tx_sending  = (count != '0) || (state != IDLE);
    assign uart_tx_overflow = overflow;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a line monitor decodes frames and checks them against a
// queue of bytes the stimulus expects to be accepted.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] uart_tx_data;
    logic       uart_tx_sending;
    logic       uart_tx_full;
    logic       uart_tx_overflow;
    logic       tx;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .uart_tx_data     (uart_tx_data),
        .uart_tx_sending  (uart_tx_sending),
        .uart_tx_full     (uart_tx_full),
        .uart_tx_overflow (uart_tx_overflow),
        .tx               (tx)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic        tog;
    logic [7:0]  exp_q [$];
    int unsigned starts [$];
    int unsigned frames = 0;

    logic [7:0]  m_byte;
    int unsigned m_start;
    logic        m_abort;
    logic        m_start_bit;
    logic        m_stop_bit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, output int unsigned k);
        @(posedge clk);
        #1;
        tog = ~tog;
        uart_tx_data = {tog, b};
        k = cyc;
    endtask

    task automatic wait_frames(input int unsigned n, input int unsigned budget);
        int unsigned t = 0;
        while (frames < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("frame_timeout", 32'(frames >= n), 32'd1);
    endtask

    task automatic pulse_rst(input int unsigned len);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (len) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Line monitor: samples mid-bit on negedges; frames overlapped by reset are discarded.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                m_start = cyc;
                m_abort = 1'b0;
                repeat (CPB / 2) begin @(negedge clk); m_abort |= rst; end
                m_start_bit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(negedge clk); m_abort |= rst; end
                    m_byte[i] = tx;
                end
                repeat (CPB) begin @(negedge clk); m_abort |= rst; end
                m_stop_bit = tx;
                if (!m_abort) begin
                    chk("start_bit", 32'(m_start_bit), 32'd0);
                    chk("stop_bit", 32'(m_stop_bit), 32'd1);
                    chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) chk("frame_byte", 32'(m_byte), 32'(exp_q.pop_front()));
                    starts.push_back(m_start);
                    frames++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned k;
        int unsigned k2;
        int unsigned f0;

        rst = 1'b1;
        tog = 1'b1;
        uart_tx_data = 9'h1FF;
        repeat (50) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_sending", 32'(uart_tx_sending), 32'd0);
        chk("reset_full", 32'(uart_tx_full), 32'd0);
        chk("reset_overflow", 32'(uart_tx_overflow), 32'd0);
        chk("reset_no_frame", frames, 32'd0);

        // Single byte: latency, frame length, sending window
        exp_q.push_back(8'hA5);
        send(8'hA5, k);
        wait_until(k + 1);
        chk("a5_sending_start", 32'(uart_tx_sending), 32'd1);
        wait_until(k + 2);
        chk("a5_tx_before_start", 32'(tx), 32'd1);
        wait_until(k + 3);
        chk("a5_tx_start_low", 32'(tx), 32'd0);
        wait_until(k + 41);
        chk("a5_sending_in_stop", 32'(uart_tx_sending), 32'd1);
        wait_until(k + 43);
        chk("a5_sending_done", 32'(uart_tx_sending), 32'd0);
        wait_frames(1, 200);
        if (starts.size() >= 1) chk("a5_latency", starts[0] - k, 32'd3);

        // Three writes on consecutive cycles: contiguous frames in order
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        send(8'h01, k);
        send(8'h02, k2);
        send(8'h03, k2);
        wait_frames(4, 400);
        if (starts.size() >= 4) begin
            chk("burst_latency", starts[1] - k, 32'd3);
            chk("burst_gap_1", starts[2] - starts[1], FRAME);
            chk("burst_gap_2", starts[3] - starts[2], FRAME);
        end
        repeat (5) @(negedge clk);
        chk("burst_idle_sending", 32'(uart_tx_sending), 32'd0);

        // Six writes in a row: fifth fills the FIFO, sixth is dropped
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h11 + 8'(i));
        for (int i = 0; i < 6; i++) send(8'h11 + 8'(i), k2);
        wait_until(k2 + 1);
        chk("ovf_full", 32'(uart_tx_full), 32'd1);
        chk("ovf_sticky_set", 32'(uart_tx_overflow), 32'd1);
        wait_frames(9, 5 * FRAME + 100);
        if (starts.size() >= 9) chk("ovf_frames_contiguous", starts[8] - starts[4], 4 * FRAME);
        repeat (10) @(negedge clk);
        chk("ovf_still_set", 32'(uart_tx_overflow), 32'd1);
        chk("ovf_full_cleared", 32'(uart_tx_full), 32'd0);
        chk("ovf_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset while 8'h5A is in its data bits with two bytes queued
        pulse_rst(2);
        @(negedge clk);
        chk("rst_clears_overflow", 32'(uart_tx_overflow), 32'd0);
        send(8'h5A, k);
        send(8'h33, k2);
        send(8'h44, k2);
        wait_until(k + 15);
        chk("mid_sending_before", 32'(uart_tx_sending), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_until(k + 17);
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_sending", 32'(uart_tx_sending), 32'd0);
        chk("mid_rst_full", 32'(uart_tx_full), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        f0 = frames;
        repeat (200) @(negedge clk);
        chk("mid_no_frames", frames, f0);
        chk("mid_idle_tx", 32'(tx), 32'd1);
        chk("mid_idle_sending", 32'(uart_tx_sending), 32'd0);

        // FIFO full and a write landing on the STOP->START pop edge
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h21 + 8'(i));
        send(8'h21, k);
        for (int i = 1; i < 5; i++) send(8'h21 + 8'(i), k2);
        wait_until(k + 40);
        chk("edge_full_before", 32'(uart_tx_full), 32'd1);
        send(8'h26, k2);
        chk("edge_write_cycle", k2, k + 41);
        wait_until(k + 42);
        chk("edge_full_after", 32'(uart_tx_full), 32'd1);
        chk("edge_no_overflow", 32'(uart_tx_overflow), 32'd0);
        wait_frames(f0 + 6, 6 * FRAME + 100);
        if (starts.size() >= f0 + 6) chk("edge_frames_contiguous", starts[f0 + 5] - starts[f0], 5 * FRAME);
        repeat (10) @(negedge clk);
        chk("edge_overflow_final", 32'(uart_tx_overflow), 32'd0);
        chk("edge_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("edge_idle_sending", 32'(uart_tx_sending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
